// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and the
// datapath mux select codes that the datapath wiring reuses.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_out_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from (state, mem_ready, zero) to the datapath control bundle.
// Enables gated by mem_ready stay low during memory stall cycles.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t    state,
    input  logic      mem_ready,
    input  logic      zero,
    output ctrl_out_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsrc    = PCSRC_ALU;
                ctrl.ir_write = mem_ready;
                ctrl.pc_write = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed while the opcode is decoded
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = mem_ready;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst    = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_REGB;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsrc    = PCSRC_ALUOUT;
                ctrl.pc_write = zero;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc    = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control unit: state register and next-state logic,
// with output decode delegated to ctrl_out_decode.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 (waits on mem_ready)
// DECODE | decode opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | read data memory (waits on mem_ready)
// MEMWB  | write MDR to rt
// MEMWR  | write data memory (waits on mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | compare and conditionally load branch target
// ADDIEX | ALU add with immediate
// ADDIWB | write ALUOut to rt
// JUMP   | load jump target
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            ir_write,
    output logic            mem_write,
    output logic            reg_write,
    output logic            iord,
    output logic            memtoreg,
    output logic            regdst,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [1:0]      aluop,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    state_t    state_q;
    state_t    state_nx;
    logic      is_store;
    logic      op_illegal;
    ctrl_out_t ctrl;

    // Opcode is only looked at in DECODE, so load vs store is latched there
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            is_store <= 1'b0;
        end else begin
            state_q <= state_nx;
            if (state_q == S_DECODE)
                is_store <= (opcode == OP_SW);
        end
    end

    always_comb begin
        state_nx   = S_FETCH;
        op_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXEC;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
                    default: begin
                        state_nx   = S_FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_nx = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nx = S_ALUWB;
            S_ADDIEX: state_nx = S_ADDIWB;
            default:  state_nx = S_FETCH;
        endcase
    end

    ctrl_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    // Reset forces every output quiet, even before the first reset edge lands
    assign pc_write  = reset ? 1'b0 : ctrl.pc_write;
    assign ir_write  = reset ? 1'b0 : ctrl.ir_write;
    assign mem_write = reset ? 1'b0 : ctrl.mem_write;
    assign reg_write = reset ? 1'b0 : ctrl.reg_write;
    assign iord      = reset ? 1'b0 : ctrl.iord;
    assign memtoreg  = reset ? 1'b0 : ctrl.memtoreg;
    assign regdst    = reset ? 1'b0 : ctrl.regdst;
    assign alusrca   = reset ? 1'b0 : ctrl.alusrca;
    assign alusrcb   = reset ? 2'b00 : ctrl.alusrcb;
    assign pcsrc     = reset ? 2'b00 : ctrl.pcsrc;
    assign aluop     = reset ? 2'b00 : ctrl.aluop;
    assign illegal   = reset ? 1'b0 : op_illegal;
    assign state     = reset ? '0 : ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected state/outputs are
// queued as inputs are driven and compared at the following negedge.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write;
    logic       iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    multicycle_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_st = 0;
    logic m_store = 1'b0;
    logic rw_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] model_out(input int st, input logic mr, input logic z,
                                              input logic [5:0] op, input logic rst);
        logic pcw, irw, mw, rw, io, m2r, rd, sa, il;
        logic [1:0] srcb, ps, ao;
        {pcw, irw, mw, rw, io, m2r, rd, sa, il} = '0;
        srcb = 2'b00; ps = 2'b00; ao = 2'b00;
        if (!rst) begin
            case (st)
                0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
                1:  begin
                        srcb = 2'b11;
                        il = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                               op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
                    end
                2:  begin sa = 1'b1; srcb = 2'b10; end
                3:  io = 1'b1;
                4:  begin m2r = 1'b1; rw = 1'b1; end
                5:  begin io = 1'b1; mw = mr; end
                6:  begin sa = 1'b1; ao = 2'b10; end
                7:  begin rd = 1'b1; rw = 1'b1; end
                8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pcw = z; end
                9:  begin sa = 1'b1; srcb = 2'b10; end
                10: rw = 1'b1;
                11: begin ps = 2'b10; pcw = 1'b1; end
                default: ;
            endcase
        end
        return {pcw, irw, mw, rw, io, m2r, rd, sa, srcb, ps, ao, il};
    endfunction

    function automatic int model_next(input int st, input logic mr, input logic [5:0] op,
                                      input logic store);
        case (st)
            0: return mr ? 1 : 0;
            1: case (op)
                   6'b100011, 6'b101011: return 2;
                   6'b000000: return 6;
                   6'b000100: return 8;
                   6'b001000: return 9;
                   6'b000010: return 11;
                   default:   return 0;
               endcase
            2: return store ? 5 : 3;
            3: return mr ? 4 : 3;
            5: return mr ? 0 : 5;
            6: return 7;
            9: return 10;
            default: return 0;
        endcase
    endfunction

    // One clock: drive inputs, queue the expectation, advance the model past the edge
    task automatic step(input logic mr, input logic z, input logic [5:0] op, input logic rst);
        exp_t e;
        reset = rst; mem_ready = mr; zero = z; opcode = op;
        e.st  = rst ? 4'd0 : 4'(m_st);
        e.vec = model_out(m_st, mr, z, op, rst);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            m_st = 0;
            m_store = 1'b0;
        end else begin
            if (m_st == 1) m_store = (op == 6'b101011);
            m_st = model_next(m_st, mr, op, m_store);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("outputs", 32'({pc_write, ir_write, mem_write, reg_write, iord, memtoreg, regdst,
                                alusrca, alusrcb, pcsrc, aluop, illegal}), 32'(e.vec));
            chk("write_exclusive", 32'($countones({mem_write, reg_write, ir_write}) <= 1), 32'd1);
            if (reg_write) rw_seen = 1'b1;
        end
    end

    // Runs one instruction from FETCH back to FETCH, stalling mem_ready as asked
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input int fstall, input int mstall, input int exp_cpi);
        int   cyc = 0;
        int   fs = fstall;
        int   ms = mstall;
        logic left = 1'b0;
        logic mr;
        logic [5:0] o;
        logic zz;
        while (!(left && m_st == 0) && cyc < 40) begin
            mr = 1'b1;
            if (m_st == 0 && fs > 0) begin mr = 1'b0; fs--; end
            if ((m_st == 3 || m_st == 5) && ms > 0) begin mr = 1'b0; ms--; end
            o  = (m_st == 1) ? op : 6'($urandom);
            zz = (m_st == 8) ? z : 1'($urandom);
            step(mr, zz, o, 1'b0);
            cyc++;
            if (m_st != 0) left = 1'b1;
        end
        chk(tag, 32'(cyc), 32'(exp_cpi));
    endtask

    initial begin
        int guard;
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'd0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b1, 1'b0, 6'd0, 1'b1);

        run_instr("cpi_lw",       6'b100011, 1'b0, 0, 0, 5);
        run_instr("cpi_sw_stall", 6'b101011, 1'b0, 0, 2, 6);
        run_instr("cpi_beq_z1",   6'b000100, 1'b1, 0, 0, 3);
        run_instr("cpi_beq_z0",   6'b000100, 1'b0, 0, 0, 3);
        run_instr("cpi_illegal",  6'b111111, 1'b0, 0, 0, 2);
        run_instr("cpi_j",        6'b000010, 1'b0, 0, 0, 3);
        run_instr("cpi_rtype",    6'b000000, 1'b0, 0, 0, 4);
        run_instr("cpi_addi",     6'b001000, 1'b0, 0, 0, 4);
        run_instr("cpi_lw_stall", 6'b100011, 1'b0, 1, 2, 8);
        run_instr("cpi_sw",       6'b101011, 1'b0, 1, 0, 5);
        run_instr("cpi_illegal2", 6'b010101, 1'b1, 2, 0, 4);

        // Reset arriving in MEMRD, first while stalled, then overriding mem_ready
        for (int k = 0; k < 2; k++) begin
            rw_seen = 1'b0;
            guard = 0;
            while (m_st != 3 && guard < 10) begin
                step(1'b1, 1'b0, 6'b100011, 1'b0);
                guard++;
            end
            chk("reach_memrd", 32'(m_st), 32'd3);
            step(1'b0, 1'b0, 6'b100011, 1'b0);
            step(k == 1, 1'b0, 6'b100011, 1'b1);
            step(1'b0, 1'b0, 6'b100011, 1'b0);
            chk("no_reg_write_after_reset", 32'(rw_seen), 32'd0);
        end
        run_instr("cpi_rtype_b2b", 6'b000000, 1'b0, 0, 0, 4);
        run_instr("cpi_addi_b2b",  6'b001000, 1'b0, 0, 0, 4);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle control unit for the processor datapath.
- Decodes the 6-bit opcode captured in the instruction register.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the select inputs of the datapath 2:1 and 4:1 multiplexers (ALUSrcA, ALUSrcB, IorD, MemtoReg, RegDst, PCSrc) plus all write enables.
- Sits directly upstream of the mux layer: every mux select in the datapath originates here.

Parameters:
- OP_W, 6: opcode width.
- ST_W, 4: state-register width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OP_W  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction register load enable.
- mem_write  out  1  data-memory write strobe.
- reg_write  out  1  register-file write enable.
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  writeback mux select: 0 = ALUOut, 1 = MDR.
- regdst  out  1  destination mux select: 0 = rt, 1 = rd.
- alusrca  out  1  ALU A mux select: 0 = PC, 1 = regA.
- alusrcb  out  2  ALU B mux4 select: 00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- pcsrc  out  2  PC mux4 select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  ST_W  current state, for debug and the bench.

Behaviour:
- States (encoding):
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
  - Codes 12–15 are unused and recover to FETCH on the next edge.
- Reset:
  - Reset high at an edge puts state in FETCH, whatever the current state, including mid-instruction.
  - While reset is high, every output is 0 except state = 0.
  - Reset overrides mem_ready.
- Default for all outputs is 0 unless listed below. Outputs are combinational from state, with mem_ready and zero gating only where stated.
- FETCH:
  - Outputs: iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, aluop = 00 (branch target precompute).
  - Next state by opcode:
    - 100011 (LW) or 101011 (SW) → MEMADR.
    - 000000 (R-type) → EXEC.
    - 000100 (BEQ) → BRANCH.
    - 001000 (ADDI) → ADDIEX.
    - 000010 (J) → JUMP.
    - Any other opcode: illegal = 1 this cycle, next state FETCH.
- MEMADR:
  - Outputs: alusrca = 1, alusrcb = 10, aluop = 00.
  - LW → MEMRD; SW → MEMWR.
- MEMRD:
  - Outputs: iord = 1.
  - Wait for mem_ready, then → MEMWB.
- MEMWB:
  - Outputs: regdst = 0, memtoreg = 1, reg_write = 1.
  - → FETCH.
- MEMWR:
  - Outputs: iord = 1, mem_write = mem_ready.
  - Wait for mem_ready, then → FETCH.
- EXEC:
  - Outputs: alusrca = 1, alusrcb = 00, aluop = 10.
  - → ALUWB.
- ALUWB:
  - Outputs: regdst = 1, memtoreg = 0, reg_write = 1.
  - → FETCH.
- BRANCH:
  - Outputs: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, pc_write = zero.
  - → FETCH.
- ADDIEX:
  - Outputs: alusrca = 1, alusrcb = 10, aluop = 00.
  - → ADDIWB.
- ADDIWB:
  - Outputs: regdst = 0, memtoreg = 0, reg_write = 1.
  - → FETCH.
- JUMP:
  - Outputs: pcsrc = 10, pc_write = 1.
  - → FETCH.
- Cycles per instruction with mem_ready tied to 1:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No enable fires during a stall cycle.
- Opcode is sampled only in DECODE; changes in any other state are ignored.
- Invariant: mem_write, reg_write and ir_write are never high in the same cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - alusrcb, pcsrc and aluop select encodings, reused by the datapath mux wiring.
- One sub-module, ctrl_out_decode: purely combinational, maps (state, mem_ready, zero) to the output bundle.
- The FSM top holds the state register and next-state logic only.

Test Plan:
- Reset/idle: hold reset 3 cycles with mem_ready = 1 → state = 0 and all enables 0. Release → ir_write = pc_write = 1 in the first cycle, alusrcb = 01.
- LW with mem_ready = 1, opcode 100011: state sequence 0,1,2,3,4,0. In state 4: reg_write = 1, memtoreg = 1, regdst = 0. In state 3: iord = 1.
- SW with a stall: opcode 101011, mem_ready = 0 for 2 cycles in MEMWR → state 5 held 3 cycles. mem_write = 1 only in the third cycle. Total instruction takes 6 cycles.
- BEQ with zero = 1 then zero = 0: in state 8, pc_write = 1, pcsrc = 01, aluop = 01 when zero = 1. pc_write = 0 when zero = 0. Both return to FETCH after 3 cycles.
- Illegal and J: opcode 111111 → illegal pulses in DECODE, then state 0 next cycle. Opcode 000010 → state 11 with pcsrc = 10, pc_write = 1.
- Reset mid-instruction: assert reset while in MEMRD with mem_ready = 0 → state = 0 on the next edge, no reg_write ever asserted. Back-to-back R-type then ADDI (mem_ready = 1) → states 0,1,6,7,0,1,9,10,0.
